// File: rtl/mig_tt_sweeper.sv
// Truth-table sweeper: walks a 4-input point index through a permuted/negated map
// onto x, captures the (optionally inverted) response into tt and compares it to expect_tt.
module mig_tt_sweeper #(
    parameter int unsigned SETTLE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  perm,
    input  logic [3:0]  neg_in,
    input  logic        neg_out,
    input  logic [15:0] expect_tt,
    output logic [3:0]  x,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        match,
    output logic        perm_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [7:0]  perm_q;
    logic [3:0]  neg_in_q;
    logic        neg_out_q;
    logic [15:0] exp_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] tt_q;
    logic        match_q;
    logic        perm_err_q;

    logic [3:0]  x_s;
    logic        last_pt_s;
    logic [15:0] tt_d;

    // A valid permutation has four pairwise-distinct 2-bit fields.
    function automatic logic perm_ok(input logic [7:0] p);
        return (p[1:0] != p[3:2]) && (p[1:0] != p[5:4]) && (p[1:0] != p[7:6]) &&
               (p[3:2] != p[5:4]) && (p[3:2] != p[7:6]) && (p[5:4] != p[7:6]);
    endfunction

    // Point drive, end-of-point detection and the truth table with the current sample merged in.
    always_comb begin
        x_s = 4'b0000;
        if (state_q == S_RUN) begin
            for (int i = 0; i < 4; i++) begin
                x_s[i] = idx_q[perm_q[2*i +: 2]] ^ neg_in_q[i];
            end
        end else begin
            x_s = 4'b0000;
        end
        last_pt_s   = (cnt_q == SETTLE_C);
        tt_d        = tt_q;
        tt_d[idx_q] = y_in ^ neg_out_q;
    end

    // Sweep sequencer with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            cnt_q      <= 4'd0;
            perm_q     <= 8'd0;
            neg_in_q   <= 4'd0;
            neg_out_q  <= 1'b0;
            exp_q      <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_q       <= 16'd0;
            match_q    <= 1'b0;
            perm_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        perm_q    <= perm;
                        neg_in_q  <= neg_in;
                        neg_out_q <= neg_out;
                        exp_q     <= expect_tt;
                        idx_q     <= 4'd0;
                        cnt_q     <= 4'd0;
                        tt_q      <= 16'd0;
                        match_q   <= 1'b0;
                        if (perm_ok(perm)) begin
                            state_q    <= S_RUN;
                            busy_q     <= 1'b1;
                            perm_err_q <= 1'b0;
                        end else begin
                            state_q    <= S_DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            perm_err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (last_pt_s) begin
                        tt_q  <= tt_d;
                        cnt_q <= 4'd0;
                        // Point 15 ends the sweep; idx parks instead of wrapping.
                        if (idx_q == 4'd15) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            match_q <= (tt_d == exp_q);
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    idx_q   <= 4'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    idx_q   <= 4'd0;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign x        = x_s;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tt       = tt_q;
    assign match    = match_q;
    assign perm_err = perm_err_q;

endmodule

// File: tb/tb_mig_tt_sweeper.sv
// Bench: two sweepers (SETTLE=0 driving y=&x, SETTLE=3 driving y=x[0]) checked every cycle
// against a timeline model, plus directed sweeps with hand-computed results.
module tb_mig_tt_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start3;
    logic [7:0]  perm;
    logic [3:0]  neg_in;
    logic        neg_out;
    logic [15:0] expect_tt;

    logic [3:0]  a_x[2];
    logic        a_y[2];
    logic        a_busy[2];
    logic        a_done[2];
    logic [15:0] a_tt[2];
    logic        a_match[2];
    logic        a_perr[2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt[2] = '{0, 0};

    always #5 clk = ~clk;

    assign a_y[0] = &a_x[0];
    assign a_y[1] = a_x[1][0];

    mig_tt_sweeper #(.SETTLE(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .perm(perm), .neg_in(neg_in),
        .neg_out(neg_out), .expect_tt(expect_tt), .x(a_x[0]), .y_in(a_y[0]),
        .busy(a_busy[0]), .done(a_done[0]), .tt(a_tt[0]), .match(a_match[0]),
        .perm_err(a_perr[0])
    );

    mig_tt_sweeper #(.SETTLE(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .perm(perm), .neg_in(neg_in),
        .neg_out(neg_out), .expect_tt(expect_tt), .x(a_x[1]), .y_in(a_y[1]),
        .busy(a_busy[1]), .done(a_done[1]), .tt(a_tt[1]), .match(a_match[1]),
        .perm_err(a_perr[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    bit          m_run[2], m_done[2], m_match[2], m_perr[2];
    int          m_t[2];
    logic [7:0]  m_p[2];
    logic [3:0]  m_ni[2];
    logic [15:0] m_full[2], m_tt[2], m_ex[2];

    function automatic logic [3:0] map_x(int k, logic [7:0] p, logic [3:0] ni);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = 1'((k >> int'(p[2*i +: 2])) & 1) ^ ni[i];
        end
        return r;
    endfunction

    function automatic bit fn(int n, logic [3:0] xv);
        return (n == 0) ? (&xv) : xv[0];
    endfunction

    function automatic bit perm_valid(logic [7:0] p);
        logic [3:0] seen;
        seen = 4'b0000;
        for (int i = 0; i < 4; i++) seen[p[2*i +: 2]] = 1'b1;
        return seen == 4'hF;
    endfunction

    function automatic int per_of(int n);
        return (n == 0) ? 1 : 4;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            logic st;
            st = (n == 0) ? start0 : start3;
            if (rst) begin
                m_run[n] = 0; m_done[n] = 0; m_match[n] = 0; m_perr[n] = 0;
                m_tt[n] = 16'h0000; m_t[n] = 0;
            end else if (m_run[n]) begin
                m_t[n]++;
                if (m_t[n] == 16 * per_of(n)) begin
                    m_run[n] = 0; m_done[n] = 1;
                    m_tt[n] = m_full[n];
                    m_match[n] = (m_full[n] == m_ex[n]);
                end else begin
                    m_tt[n] = m_full[n] & ((16'h0001 << (m_t[n] / per_of(n))) - 16'h0001);
                end
            end else if (m_done[n]) begin
                m_done[n] = 0;
            end else if (st) begin
                m_p[n] = perm; m_ni[n] = neg_in; m_ex[n] = expect_tt;
                m_tt[n] = 16'h0000; m_match[n] = 0;
                for (int k = 0; k < 16; k++) m_full[n][k] = fn(n, map_x(k, perm, neg_in)) ^ neg_out;
                if (perm_valid(perm)) begin
                    m_run[n] = 1; m_t[n] = 0; m_perr[n] = 0;
                end else begin
                    m_done[n] = 1; m_perr[n] = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            logic [3:0] ex_x;
            ex_x = m_run[n] ? map_x(m_t[n] / per_of(n), m_p[n], m_ni[n]) : 4'b0000;
            chk($sformatf("u%0d_x", n), 32'(a_x[n]), 32'(ex_x));
            chk($sformatf("u%0d_busy", n), 32'(a_busy[n]), 32'(m_run[n]));
            chk($sformatf("u%0d_done", n), 32'(a_done[n]), 32'(m_done[n]));
            chk($sformatf("u%0d_tt", n), 32'(a_tt[n]), 32'(m_tt[n]));
            chk($sformatf("u%0d_match", n), 32'(a_match[n]), 32'(m_match[n]));
            chk($sformatf("u%0d_perm_err", n), 32'(a_perr[n]), 32'(m_perr[n]));
            if (a_done[n] === 1'b1) done_cnt[n]++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic run_sweep(input int n, input logic [7:0] p, input logic [3:0] ni,
                             input logic no, input logic [15:0] ex, input logic [15:0] exp_tt,
                             input logic exp_match, input logic exp_perr, input int exp_lat,
                             input string nm);
        int t0;
        bit got;
        perm = p; neg_in = ni; neg_out = no; expect_tt = ex;
        if (n == 0) start0 = 1'b1; else start3 = 1'b1;
        t0 = cyc + 1;
        tick(1);
        start0 = 1'b0; start3 = 1'b0;
        perm = ~p; neg_in = ~ni; neg_out = ~no; expect_tt = ~ex;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            if (a_done[n] === 1'b1) begin
                got = 1;
                break;
            end
            tick(1);
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
        chk({nm, "_tt"}, 32'(a_tt[n]), 32'(exp_tt));
        chk({nm, "_match"}, 32'(a_match[n]), 32'(exp_match));
        chk({nm, "_perm_err"}, 32'(a_perr[n]), 32'(exp_perr));
        tick(2);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start0 = 1'b0; start3 = 1'b0;
        perm = 8'hE4; neg_in = 4'h0; neg_out = 1'b0; expect_tt = 16'h0000;
        tick(3);
        chk("reset_x", 32'(a_x[0]), 32'd0);
        chk("reset_busy", 32'(a_busy[0]), 32'd0);
        chk("reset_done", 32'(a_done[0]), 32'd0);
        chk("reset_tt", 32'(a_tt[0]), 32'd0);
        chk("reset_match", 32'(a_match[0]), 32'd0);
        chk("reset_perm_err", 32'(a_perr[0]), 32'd0);
        rst = 1'b0;
        tick(2);

        run_sweep(0, 8'hE4, 4'h0, 1'b0, 16'h8000, 16'h8000, 1'b1, 1'b0, 16, "and_plain");
        run_sweep(0, 8'hE4, 4'hF, 1'b1, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 16, "and_neg");
        run_sweep(0, 8'hE4, 4'hF, 1'b1, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0, 16, "and_neg2");
        run_sweep(1, 8'h1B, 4'h0, 1'b0, 16'hFF00, 16'hFF00, 1'b1, 1'b0, 64, "x0_settle3");
        run_sweep(1, 8'hE4, 4'h0, 1'b0, 16'hAAAA, 16'hAAAA, 1'b1, 1'b0, 64, "x0_ident");
        run_sweep(0, 8'h00, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, "bad_perm00");
        run_sweep(0, 8'hE5, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, "bad_permE5");

        // Abort 5 cycles into a sweep.
        perm = 8'hE4; neg_in = 4'h0; neg_out = 1'b0; expect_tt = 16'h8000;
        start0 = 1'b1; tick(1); start0 = 1'b0;
        tick(4);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("abort_busy", 32'(a_busy[0]), 32'd0);
        chk("abort_x", 32'(a_x[0]), 32'd0);
        chk("abort_tt", 32'(a_tt[0]), 32'd0);
        d0 = done_cnt[0];
        tick(30);
        chk("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
        run_sweep(0, 8'hE4, 4'h0, 1'b0, 16'h8000, 16'h8000, 1'b1, 1'b0, 16, "after_abort");

        // Starts during a sweep are ignored.
        d0 = done_cnt[0];
        start0 = 1'b1; tick(1); start0 = 1'b0;
        tick(2); start0 = 1'b1; tick(1); start0 = 1'b0;
        tick(6); start0 = 1'b1; tick(1); start0 = 1'b0;
        tick(30);
        chk("ignored_starts_one_done", 32'(done_cnt[0] - d0), 32'd1);

        // Start held high: sweeps every 18 edges, four fit in the 60-edge window.
        d0 = done_cnt[0];
        start0 = 1'b1; tick(60); start0 = 1'b0;
        tick(20);
        chk("held_start_dones", 32'(done_cnt[0] - d0), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/mig_tt_sweeper.md
MIG_TT_SWEEPER -- requirements
Module: mig_tt_sweeper

Interface
REQ-001 SHALL have parameter SETTLE, default 0, range 0..15: extra wait cycles between driving a point on x and sampling y_in.
REQ-002 SHALL use one clock; reset is synchronous and active-high (ports clk, rst below).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  request a sweep; sampled in IDLE only.
REQ-006 SHALL have port perm  input  8  input permutation; perm[2i+1:2i] selects which idx bit drives x[i].
REQ-007 SHALL have port neg_in  input  4  input negation mask applied after permutation.
REQ-008 SHALL have port neg_out  input  1  output negation applied to y_in before capture.
REQ-009 SHALL have port expect_tt  input  16  expected truth table for the comparison.
REQ-010 SHALL have port x  output  4  drive to the external 4-input combinational function under test.
REQ-011 SHALL have port y_in  input  1  function output, combinational from x.
REQ-012 SHALL have port busy  output  1  sweep in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port tt  output  16  captured truth table; bit k holds the transformed output for point k.
REQ-015 SHALL have port match  output  1  tt == latched expect_tt; valid from done onward.
REQ-016 SHALL have port perm_err  output  1  perm was not a permutation of {0,1,2,3}; valid with done.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 In IDLE, start=1 SHALL latch perm, neg_in, neg_out and expect_tt; later changes to these inputs SHALL NOT affect the sweep.
REQ-019 On the start edge with a valid perm: go to RUN, busy=1, idx=0, settle counter=0, tt=0, match=0, perm_err=0.
REQ-020 On the start edge with an invalid perm (any repeated 2-bit field): go to DONE directly; busy stays 0; tt=0; match=0; perm_err=1.
REQ-021 In RUN, x[i] SHALL equal idx[perm[2i+1:2i]] ^ neg_in[i], driven combinationally from the registered idx.
REQ-022 Each point SHALL last SETTLE+1 cycles. At the last edge of the point: tt[idx] <= y_in ^ neg_out, idx increments, and the settle counter clears.
REQ-023 Timing: with the start edge at T0, point k SHALL be sampled at edge T0+(k+1)(SETTLE+1). busy SHALL fall and done SHALL rise at edge T0+16(SETTLE+1).
REQ-024 tt SHALL update bit by bit during RUN; bits not yet sampled SHALL read 0.
REQ-025 idx SHALL NOT wrap. Capture of point 15 SHALL transition RUN to DONE.
REQ-026 DONE SHALL last exactly one cycle with done=1 and match=(tt==latched expect_tt), then return to IDLE.
REQ-027 tt, match and perm_err SHALL hold their values in IDLE until the next accepted start.
REQ-028 start asserted in RUN or DONE SHALL be ignored and not queued.
REQ-029 start held high continuously SHALL begin a new sweep on the first IDLE cycle after DONE.
REQ-030 x SHALL be 4'b0000 whenever state is not RUN.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, idx=0, settle counter=0, x=0, busy=0, done=0, tt=0, match=0, perm_err=0.
REQ-032 rst SHALL take priority over start.
REQ-033 rst during RUN SHALL abort the sweep with no done pulse.
REQ-034 rst in the DONE cycle SHALL clear done on that edge.

Verification
REQ-035 SETTLE=0, DUT y=&x, perm=8'hE4, neg_in=0, neg_out=0, expect_tt=16'h8000, start -> done exactly 16 cycles after the start edge, tt=16'h8000, match=1, perm_err=0.
REQ-036 Same DUT, neg_in=4'hF, neg_out=1, expect_tt=16'h0001 -> tt=16'hFFFE, match=0; a second run with expect_tt=16'hFFFE -> match=1.
REQ-037 SETTLE=3, DUT y=x[0], perm=8'h1B (reversed) -> done 64 cycles after the start edge, tt=16'hFF00; on every sampling edge x has been stable for 4 cycles.
REQ-038 perm=8'h00, start -> done on the next cycle, perm_err=1, busy never 1, x stays 0, tt=0.
REQ-039 rst asserted 5 cycles into a sweep -> all outputs 0 the next cycle and no done pulse; a following start produces a full correct sweep.
REQ-040 start pulsed at cycles 3 and 10 of a sweep -> ignored, done occurs exactly once; start held high -> back-to-back sweeps, with one IDLE cycle between each done and the next busy.
